// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Latency: request handshake at edge N -> respN_valid high after edge N+1; at most one op per 3 cycles.
// Backpressure: both req readies are low outside IDLE; a response is held until its resp_ready is seen.
//
// Ports:
//   clk, rst_n                 clock (rising edge) and asynchronous active-low reset
//   reqN_valid/ready/a/b/op    request channel of requester N (N = 0, 1)
//   respN_valid/ready/result/zero  response channel of requester N
//   alu_a/alu_b/alu_op         registered operands/op driven to the external ALU
//   alu_result/alu_zero        result and zero flag returned by the ALU
// Optional feature macro: ALU_ARBITER_OPCHK_EN adds resp0_err/resp1_err and rejects op codes 10-15.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_zero,
`ifdef ALU_ARBITER_OPCHK_EN
  output logic             resp0_err,
  output logic             resp1_err,
`endif
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_gnt;   // requester owning the in-flight op
  logic             r_last;  // requester granted most recently
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic             r_vld0;
  logic             r_vld1;
  logic [WIDTH-1:0] r_res0;
  logic [WIDTH-1:0] r_res1;
  logic             r_zero0;
  logic             r_zero1;

  logic             w_gnt;
  logic             w_hs;
  logic             w_rdy0;
  logic             w_rdy1;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [OPW-1:0]   w_op;

  // Round robin: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    w_gnt = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt = ~r_last;
    end else if (req1_valid) begin
      w_gnt = 1'b1;
    end
  end

  assign w_a  = w_gnt ? req1_a  : req0_a;
  assign w_b  = w_gnt ? req1_b  : req0_b;
  assign w_op = w_gnt ? req1_op : req0_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    w_hs   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rdy0 = req0_valid && !w_gnt;
        w_rdy1 = req1_valid && w_gnt;
        w_hs   = (req0_valid && w_rdy0) || (req1_valid && w_rdy1);
        if (w_hs) begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        if (r_gnt ? resp1_ready : resp0_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

`ifdef ALU_ARBITER_OPCHK_EN
  logic r_err;
  logic r_err0;
  logic r_err1;
  logic w_illegal;

  assign w_illegal = (w_op > OPW'(9));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_vld0  <= 1'b0;
      r_vld1  <= 1'b0;
      r_res0  <= '0;
      r_res1  <= '0;
      r_zero0 <= 1'b0;
      r_zero1 <= 1'b0;
`ifdef ALU_ARBITER_OPCHK_EN
      r_err   <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_gnt  <= w_gnt;
            r_last <= w_gnt;
`ifdef ALU_ARBITER_OPCHK_EN
            // An illegal op is replaced by ADD 0,0 so the ALU sees a harmless operation.
            r_err  <= w_illegal;
            r_a    <= w_illegal ? '0 : w_a;
            r_b    <= w_illegal ? '0 : w_b;
            r_op   <= w_illegal ? '0 : w_op;
`else
            r_a    <= w_a;
            r_b    <= w_b;
            r_op   <= w_op;
`endif
          end
        end
        S_EXEC: begin
          if (r_gnt) begin
            r_vld1  <= 1'b1;
`ifdef ALU_ARBITER_OPCHK_EN
            r_res1  <= r_err ? '0 : alu_result;
            r_zero1 <= r_err ? 1'b1 : alu_zero;
            r_err1  <= r_err;
`else
            r_res1  <= alu_result;
            r_zero1 <= alu_zero;
`endif
          end else begin
            r_vld0  <= 1'b1;
`ifdef ALU_ARBITER_OPCHK_EN
            r_res0  <= r_err ? '0 : alu_result;
            r_zero0 <= r_err ? 1'b1 : alu_zero;
            r_err0  <= r_err;
`else
            r_res0  <= alu_result;
            r_zero0 <= alu_zero;
`endif
          end
        end
        S_RESP: begin
          if (r_gnt && resp1_ready) begin
            r_vld1 <= 1'b0;
          end
          if (!r_gnt && resp0_ready) begin
            r_vld0 <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req0_ready   = w_rdy0;
  assign req1_ready   = w_rdy1;
  assign resp0_valid  = r_vld0;
  assign resp1_valid  = r_vld1;
  assign resp0_result = r_res0;
  assign resp1_result = r_res1;
  assign resp0_zero   = r_zero0;
  assign resp1_zero   = r_zero1;
`ifdef ALU_ARBITER_OPCHK_EN
  assign resp0_err    = r_err0;
  assign resp1_err    = r_err1;
`endif

  // ALU inputs come straight from registers: stable for the whole EXEC cycle,
  // holding their last value elsewhere, never combinationally from the requesters.
  assign alu_a  = r_a;
  assign alu_b  = r_b;
  assign alu_op = r_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: behavioural ALU model, directed requesters, scoreboard monitor.
// Latency: expectations are pushed at the request handshake and popped on response handshakes.
// Backpressure: resp readies are changed only just after a rising edge.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic [31:0] resp0_result, resp1_result;
  logic        resp0_zero, resp1_zero;
  logic        resp0_err, resp1_err;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result), .resp0_zero(resp0_zero),
`ifdef ALU_ARBITER_OPCHK_EN
    .resp0_err(resp0_err), .resp1_err(resp1_err),
`endif
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result), .resp1_zero(resp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero)
  );

`ifndef ALU_ARBITER_OPCHK_EN
  assign resp0_err = 1'b0;
  assign resp1_err = 1'b0;
`endif

  // Reference ALU sitting on the arbiter's ALU port.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd5: alu_result = alu_a << alu_b[4:0];
      4'd6: alu_result = alu_a >> alu_b[4:0];
      4'd7: alu_result = $signed(alu_a) >>> alu_b[4:0];
      4'd8: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'd9: alu_result = {31'b0, alu_a < alu_b};
      default: alu_result = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp0_valid || resp1_valid) begin
        chk("resp_onehot", {63'b0, resp0_valid && resp1_valid}, 64'd0);
      end
      for (int ch = 0; ch < 2; ch++) begin
        logic        v, r, z, e;
        logic [31:0] res;
        v   = (ch == 0) ? resp0_valid  : resp1_valid;
        r   = (ch == 0) ? resp0_ready  : resp1_ready;
        res = (ch == 0) ? resp0_result : resp1_result;
        z   = (ch == 0) ? resp0_zero   : resp1_zero;
        e   = (ch == 0) ? resp0_err    : resp1_err;
        if (v && r) begin
          grant_log.push_back(ch);
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp: channel %0d result %h with nothing outstanding", ch, res);
          end else begin
            exp_t x;
            x = sb.pop_front();
            chk("resp", {29'b0, ch[0], res, z, e}, {29'b0, x.id, x.res, x.zero, x.err});
          end
        end
      end
    end
  end

  // Presents one request (call just after a rising edge) and returns just after its handshake edge.
  task automatic drive(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic z, input logic e);
    bit done;
    done = 0;
    if (id == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        exp_t x;
        x.id = id[0]; x.res = res; x.zero = z; x.err = e;
        sb.push_back(x);
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req%0d_timeout: ready never seen, expected a grant", id);
    end
    @(posedge clk);
    #1;
    // Scrambled operands after the handshake must not affect the result.
    if (id == 0) begin
      req0_valid = 1'b0; req0_a = 32'hA5A5A5A5; req0_b = 32'h5A5A5A5A; req0_op = 4'd3;
    end else begin
      req1_valid = 1'b0; req1_a = 32'hA5A5A5A5; req1_b = 32'h5A5A5A5A; req1_op = 4'd3;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {32'b0, req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_zero, resp1_zero,
               resp0_err, resp1_err, alu_op}, 64'd0);
    chk({name, "_data"}, {resp0_result, resp1_result}, 64'd0);
    chk({name, "_alu"}, {alu_a, alu_b}, 64'd0);
  endtask

  initial begin
    logic [31:0] hold_res;
    logic        hold_z;
    bit          seen;

    // Reset state
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester, latency check
    drive(0, 4'd0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
    chk("exec_resp0_low", {63'b0, resp0_valid}, 64'd0);
    chk("exec_alu", {alu_a, alu_b}, {32'd10, 32'd20});
    chk("exec_alu_op_rdy", {58'b0, alu_op, req0_ready, req1_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("resp_rise", {62'b0, resp0_valid, resp1_valid}, {62'b0, 2'b10});
    drain();

    // Simultaneous after reset: req0 first (last_grant resets to 1)
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    grant_log.delete();
    fork
      drive(0, 4'd1, 32'd10, 32'd10, 32'd0, 1'b1, 1'b0);
      drive(1, 4'd4, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 1'b0);
    join
    drain();
    chk("simul_order", {grant_log.size() == 2 ? grant_log[0] : -1, grant_log.size() == 2 ? grant_log[1] : -1},
        {32'd0, 32'd1});

    // Fairness: both keep requesting
    grant_log.delete();
    fork
      begin
        drive(0, 4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        drive(0, 4'd2, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0);
        drive(0, 4'd3, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0);
      end
      begin
        drive(1, 4'd7, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0);
        drive(1, 4'd5, 32'd1, 32'd8, 32'h00000100, 1'b0, 1'b0);
        drive(1, 4'd6, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1'b0);
      end
    join
    drain();
    chk("fair_count", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      chk("fair_order", 64'(grant_log[i]), 64'(i % 2));
    end

    // Backpressure on response channel 1 while req0 waits
    resp1_ready = 1'b0;
    drive(1, 4'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0);
    fork
      drive(0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      begin
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
          @(negedge clk);
          seen = resp1_valid;
        end
        chk("bp_valid_seen", {63'b0, seen}, 64'd1);
        hold_res = resp1_result;
        hold_z   = resp1_zero;
        for (int i = 0; i < 5; i++) begin
          chk("bp_hold", {30'b0, resp1_valid, req0_ready, resp1_result}, {30'b0, 2'b10, hold_res});
          chk("bp_zero", {63'b0, resp1_zero}, {63'b0, hold_z});
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp1_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_done", {63'b0, resp1_valid}, 64'd0);
      end
    join
    drain();

    // Reset in the middle of EXEC drops the op
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = req0_ready;
    end
    chk("rst_req_grant", {63'b0, seen}, 64'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_exec");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_resp", {62'b0, resp0_valid, resp1_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    drive(1, 4'd8, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    drive(1, 4'd9, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    drain();

`ifdef ALU_ARBITER_OPCHK_EN
    drive(0, 4'hC, 32'd5, 32'd6, 32'd0, 1'b1, 1'b1);
    chk("opchk_alu", {28'b0, alu_op, alu_a}, 64'd0);
    drive(0, 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
